stage_sequencer: RTL

//   Generates the 3-bit Stage code (1=Fetch..5=Write Back, 0=idle) consumed by the

---
 rtl/stage_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stage_sequencer
//  Purpose  : Generates the 3-bit stage code for the multicycle datapath.
//             Encodings: 0 = idle/halted, 1 = Fetch, 2 = Decode,
//             3 = Execute, 4 = Memory, 5 = Write Back.
//             The sequencer advances one stage per clock. It stretches the
//             Memory stage until memory signals ready, or until a timeout
//             expires. It also supports a global stall and a halt that takes
//             effect at an instruction boundary, and it counts retired
//             instructions.
//  Ports    : Clock        - system clock, rising edge
//             Reset        - synchronous, active-high
//             Run          - fetch the next instruction when idle / after WB
//             Stall        - hold all sequencing state this cycle
//             Halt_Req     - request a stop at the next instruction boundary
//             Mem_Access   - current instruction uses memory in stage 4
//             Mem_Ready    - memory completed its access this cycle
//             Stage        - current stage code (0..5)
//             Instr_Done   - one-cycle pulse on the cycle Stage leaves 5
//             Instr_Count  - retired-instruction count (wraps)
//             Mem_Timeout  - sticky flag: the Memory stage waited too long
//             Halted       - high while in the terminal halted state
//  Revision : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int MEM_WAIT_MAX = 8,
    parameter int COUNT_W      = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Stall,
    input  logic               Halt_Req,
    input  logic               Mem_Access,
    input  logic               Mem_Ready,
    output logic [2:0]         Stage,
    output logic               Instr_Done,
    output logic [COUNT_W-1:0] Instr_Count,
    output logic               Mem_Timeout,
    output logic               Halted
);

    // Wait counter is wide enough to hold MEM_WAIT_MAX-1 (minimum 1 bit).
    localparam int                WAIT_W      = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_F    = 3'd1;
    localparam logic [2:0] C_ST_D    = 3'd2;
    localparam logic [2:0] C_ST_E    = 3'd3;
    localparam logic [2:0] C_ST_M    = 3'd4;
    localparam logic [2:0] C_ST_W    = 3'd5;

    // HALTED is encoded as stage code 0 with r_halted_q set. This keeps the
    // Stage output a direct copy of the state register.
    logic [2:0]         r_stage_q,    w_stage_d;
    logic               r_halted_q,   w_halted_d;
    logic               r_halt_lat_q, w_halt_lat_d;
    logic [WAIT_W-1:0]  r_wait_q,     w_wait_d;
    logic [COUNT_W-1:0] r_count_q,    w_count_d;
    logic               r_timeout_q,  w_timeout_d;
    logic               w_retire;

    always_comb begin
        w_stage_d    = r_stage_q;
        w_halted_d   = r_halted_q;
        w_wait_d     = r_wait_q;
        w_count_d    = r_count_q;
        w_timeout_d  = r_timeout_q;
        w_retire     = 1'b0;
        // A halt request is captured even while stalled, so it is never lost.
        w_halt_lat_d = r_halt_lat_q | Halt_Req;

        if (!Stall && !r_halted_q) begin
            case (r_stage_q)
                C_ST_IDLE: begin
                    if (r_halt_lat_q) begin
                        w_halted_d = 1'b1;
                    end else if (Run) begin
                        w_stage_d = C_ST_F;
                    end
                end
                C_ST_F: w_stage_d = C_ST_D;
                C_ST_D: w_stage_d = C_ST_E;
                C_ST_E: w_stage_d = C_ST_M;
                C_ST_M: begin
                    if (!Mem_Access || Mem_Ready) begin
                        w_stage_d = C_ST_W;
                        w_wait_d  = '0;
                    end else if (r_wait_q == C_WAIT_LAST) begin
                        // Give up waiting: flag the timeout and retire anyway.
                        w_stage_d   = C_ST_W;
                        w_wait_d    = '0;
                        w_timeout_d = 1'b1;
                    end else begin
                        w_wait_d = r_wait_q + 1'b1;
                    end
                end
                C_ST_W: begin
                    w_retire  = 1'b1;
                    w_count_d = r_count_q + 1'b1;
                    if (r_halt_lat_q) begin
                        w_stage_d  = C_ST_IDLE;
                        w_halted_d = 1'b1;
                    end else if (Run) begin
                        w_stage_d = C_ST_F;
                    end else begin
                        w_stage_d = C_ST_IDLE;
                    end
                end
                default: begin
                    // Codes 6 and 7 are unreachable; recover to idle.
                    w_stage_d = C_ST_IDLE;
                    w_wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stage_q    <= C_ST_IDLE;
            r_halted_q   <= 1'b0;
            r_halt_lat_q <= 1'b0;
            r_wait_q     <= '0;
            r_count_q    <= '0;
            r_timeout_q  <= 1'b0;
        end else begin
            r_stage_q    <= w_stage_d;
            r_halted_q   <= w_halted_d;
            r_halt_lat_q <= w_halt_lat_d;
            r_wait_q     <= w_wait_d;
            r_count_q    <= w_count_d;
            r_timeout_q  <= w_timeout_d;
        end
    end

    assign Stage       = r_stage_q;
    assign Halted      = r_halted_q;
    assign Instr_Count = r_count_q;
    assign Mem_Timeout = r_timeout_q;
    // Instr_Done must coincide with the last Write Back cycle. Whether that
    // cycle is the last depends on this cycle's Stall and Reset, so the pulse
    // is decoded rather than registered.
    assign Instr_Done  = w_retire & ~Reset;

endmodule
`default_nettype wire
